// File: rtl/peripheral_uart_rx.sv
// J1 I/O-bus UART receiver: 16x oversampled 8N1 (8E1 with UART_RX_PARITY_EN) deserialiser feeding a small byte FIFO.
// Latency: byte visible one clk after stop-bit sample; register reads return one clk after the rd cycle.
module peripheral_uart_rx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    input  logic        uart_rx,
    output logic        rx_irq
);
    localparam int DIV = CLK_HZ / (16 * BAUD);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic          rx_meta, rx_s, rx_prev;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [2:0]    state;
    logic [3:0]    scnt;
    logic [2:0]    bcnt;
    logic [7:0]    shreg;
    logic          byte_vld, frame_set, par_set;
    logic          frame_err, overrun, parity_err;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          full, avail, rd_acc, rd_acc_q, pop, push_ok, ovr_set, err_clr;
    logic          unused_d_in;

    assign unused_d_in = ^d_in[15:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DW'(DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DW'(DIV - 1));

    // rx_prev is tracked on every tick, so a break that ends in STOP leaves
    // rx_prev low and IDLE waits for the line to go high before re-arming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            scnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            rx_prev   <= 1'b1;
            byte_vld  <= 1'b0;
            frame_set <= 1'b0;
            par_set   <= 1'b0;
        end else begin
            byte_vld  <= 1'b0;
            frame_set <= 1'b0;
            par_set   <= 1'b0;
            if (tick) begin
                rx_prev <= rx_s;
                case (state)
                    S_IDLE: begin
                        if (rx_prev && !rx_s) begin
                            scnt  <= '0;
                            state <= S_START;
                        end
                    end
                    S_START: begin
                        if (scnt == 4'd7) begin
                            scnt  <= '0;
                            bcnt  <= '0;
                            state <= rx_s ? S_IDLE : S_DATA;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        scnt <= scnt + 1'b1;
                        if (scnt == 4'd15) begin
                            shreg <= {rx_s, shreg[7:1]};
                            bcnt  <= bcnt + 1'b1;
                            if (bcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= S_PARITY;
`else
                                state <= S_STOP;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        scnt <= scnt + 1'b1;
                        if (scnt == 4'd15) begin
                            par_set <= (rx_s != ^shreg);
                            state   <= S_STOP;
                        end
                    end
`endif
                    S_STOP: begin
                        scnt <= scnt + 1'b1;
                        if (scnt == 4'd15) begin
                            byte_vld  <= rx_s;
                            frame_set <= !rx_s;
                            state     <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign avail   = (count != '0);
    assign rd_acc  = cs && rd && (addr == 4'd2);
    assign pop     = rd_acc && !rd_acc_q && avail;
    assign push_ok = byte_vld && (!full || pop);
    assign ovr_set = byte_vld && !push_ok;
    assign err_clr = cs && wr && (addr == 4'd4) && d_in[0];
    assign rx_irq  = avail;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= shreg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rd_acc_q <= 1'b0;
        end else begin
            rd_acc_q <= rd_acc;
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Set has priority over a same-cycle clear so no error event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_set ? 1'b1 : (err_clr ? 1'b0 : frame_err);
            overrun   <= ovr_set   ? 1'b1 : (err_clr ? 1'b0 : overrun);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= par_set ? 1'b1 : (err_clr ? 1'b0 : parity_err);
        end
    end
`else
    assign parity_err = 1'b0;
    logic unused_par;
    assign unused_par = par_set;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out <= '0;
        end else if (cs && rd && addr == 4'd0) begin
            d_out <= {11'b0, parity_err, overrun, frame_err, full, avail};
        end else if (rd_acc && avail) begin
            d_out <= {8'b0, mem[rptr]};
        end else begin
            d_out <= '0;
        end
    end
endmodule

// File: tb/tb_peripheral_uart_rx.sv
module tb_peripheral_uart_rx;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] d_in;
    logic        cs, rd, wr;
    logic [3:0]  addr;
    logic [15:0] d_out;
    logic        uart_rx;
    logic        rx_irq;

    int checks   = 0;
    int failures = 0;

    peripheral_uart_rx #(
        .CLK_HZ(16_000_000), .BAUD(1_000_000), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd),
        .wr(wr), .d_out(d_out), .uart_rx(uart_rx), .rx_irq(rx_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        logic [15:0] exp_status;
        logic [15:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        uart_rx = v;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic par, input logic stop);
        @(negedge clk);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_time(par);
`else
        if (par === 1'bx) uart_rx = 1'b1;
`endif
        bit_time(stop);
        uart_rx = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        d = d_out;
        cs = 1'b0; rd = 1'b0; addr = 4'd0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] v);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = v;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; addr = 4'd0; d_in = 16'h0;
    endtask

    task automatic wait_irq(input string name, input int budget);
        int n;
        n = 0;
        while (rx_irq !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {15'b0, rx_irq}, 16'h0001);
    endtask

    vec_t vecs [6];
    logic [15:0] rdat;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 16'h0001, 16'h00A5};
        vecs[1] = '{8'h3C, 1'b0, 16'h0004, 16'h0000};
        vecs[2] = '{8'h00, 1'b1, 16'h0001, 16'h0000};
        vecs[3] = '{8'hFF, 1'b1, 16'h0001, 16'h00FF};
        vecs[4] = '{8'h80, 1'b1, 16'h0001, 16'h0080};
        vecs[5] = '{8'h01, 1'b1, 16'h0001, 16'h0001};

        rst = 1'b1; uart_rx = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0;
        addr = 4'd0; d_in = 16'h0;
        repeat (3) @(negedge clk);
        check("reset_dout", d_out, 16'h0000);
        check("reset_irq", {15'b0, rx_irq}, 16'h0000);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        bus_read(4'd0, rdat);
        check("reset_status", rdat, 16'h0000);

        for (int i = 0; i < 6; i++) begin
            send_byte(vecs[i].data, ^vecs[i].data, vecs[i].stop);
            if (vecs[i].stop) wait_irq($sformatf("vec%0d_irq", i), 8);
            repeat (8) @(negedge clk);
            bus_read(4'd0, rdat);
            check($sformatf("vec%0d_status", i), rdat, vecs[i].exp_status);
            bus_read(4'd2, rdat);
            check($sformatf("vec%0d_data", i), rdat, vecs[i].exp_data);
            if (!vecs[i].stop) begin
                bus_write(4'd4, 16'h0000);
                bus_read(4'd0, rdat);
                check($sformatf("vec%0d_clr0_ignored", i), rdat, 16'h0004);
            end
            bus_write(4'd4, 16'h0001);
            bus_read(4'd0, rdat);
            check($sformatf("vec%0d_after_clr", i), rdat, 16'h0000);
        end

        // Short low glitch must be rejected and leave the receiver usable.
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_irq", {15'b0, rx_irq}, 16'h0000);
        bus_read(4'd0, rdat);
        check("glitch_status", rdat, 16'h0000);
        send_byte(8'h5A, ^8'h5A, 1'b1);
        wait_irq("glitch_recover_irq", 8);
        bus_read(4'd2, rdat);
        check("glitch_recover_data", rdat, 16'h005A);

        // Overrun: fifth byte is dropped, first four survive.
        for (int b = 1; b <= 5; b++) send_byte(8'(b), ^8'(b), 1'b1);
        repeat (8) @(negedge clk);
        bus_read(4'd0, rdat);
        check("ovr_status", rdat, 16'h000B);
        for (int b = 1; b <= 4; b++) begin
            bus_read(4'd2, rdat);
            check($sformatf("ovr_data%0d", b), rdat, 16'(b));
        end
        bus_read(4'd2, rdat);
        check("empty_read", rdat, 16'h0000);
        bus_read(4'd0, rdat);
        check("ovr_status_empty", rdat, 16'h0008);
        bus_write(4'd4, 16'h0001);
        bus_read(4'd0, rdat);
        check("ovr_cleared", rdat, 16'h0000);

        // A long rd on the data register pops exactly once.
        send_byte(8'h11, ^8'h11, 1'b1);
        send_byte(8'h22, ^8'h22, 1'b1);
        repeat (8) @(negedge clk);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = 4'd2;
        @(negedge clk);
        check("hold_first", d_out, 16'h0011);
        repeat (4) @(negedge clk);
        cs = 1'b0; rd = 1'b0; addr = 4'd0;
        bus_read(4'd2, rdat);
        check("hold_second", rdat, 16'h0022);
        bus_read(4'd0, rdat);
        check("hold_status", rdat, 16'h0000);

        // Reset in the middle of a frame drops the partial byte.
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b1; uart_rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("midrst_irq", {15'b0, rx_irq}, 16'h0000);
        bus_read(4'd0, rdat);
        check("midrst_status", rdat, 16'h0000);
        send_byte(8'h96, ^8'h96, 1'b1);
        wait_irq("midrst_recover_irq", 8);
        bus_read(4'd2, rdat);
        check("midrst_recover_data", rdat, 16'h0096);

`ifdef UART_RX_PARITY_EN
        send_byte(8'h07, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        bus_read(4'd0, rdat);
        check("par_bad_status", rdat, 16'h0011);
        bus_read(4'd2, rdat);
        check("par_bad_data", rdat, 16'h0007);
        bus_write(4'd4, 16'h0001);
        send_byte(8'h07, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        bus_read(4'd0, rdat);
        check("par_ok_status", rdat, 16'h0001);
        bus_read(4'd2, rdat);
        check("par_ok_data", rdat, 16'h0007);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
